// File: rtl/fifo_level.sv
// fifo_level: synchronous show-ahead FIFO using all 2^W entries, with an
// occupancy count, almost-full/almost-empty thresholds, a synchronous flush
// and sticky overflow/underflow flags.
module fifo_level #(
  parameter int B        = 8,
  parameter int W        = 4,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         err_clr,
  input  logic         wr,
  input  logic [B-1:0] w_data,
  input  logic         rd,
  output logic [B-1:0] r_data,
  output logic         empty,
  output logic         full,
  output logic         almost_empty,
  output logic         almost_full,
  output logic [W:0]   level,
  output logic         overflow,
  output logic         underflow
);

  localparam int unsigned D = 2 ** W;

  localparam logic [W-1:0] PTR_ZERO = W'(0);
  localparam logic [W-1:0] PTR_ONE  = W'(1);
  localparam logic [W:0]   LVL_ZERO = (W + 1)'(0);
  localparam logic [W:0]   LVL_ONE  = (W + 1)'(1);
  localparam logic [W:0]   LVL_FULL = (W + 1)'(D);
  localparam logic [W:0]   LVL_AF   = (W + 1)'(AF_LEVEL);
  localparam logic [W:0]   LVL_AE   = (W + 1)'(AE_LEVEL);

  logic [B-1:0] mem [D];

  logic [W-1:0] w_ptr_q, w_ptr_d;
  logic [W-1:0] r_ptr_q, r_ptr_d;
  logic [W:0]   level_q, level_d;
  logic         overflow_q, overflow_d;
  logic         underflow_q, underflow_d;
  logic         empty_q, empty_d;
  logic         full_q, full_d;
  logic         almost_empty_q, almost_empty_d;
  logic         almost_full_q, almost_full_d;

  logic         rd_ok_s;
  logic         wr_ok_s;
  logic         mem_we_s;
  logic         ovf_evt_s;
  logic         udf_evt_s;

  // Request acceptance: a write into a full FIFO is allowed only alongside an accepted read.
  always_comb begin
    rd_ok_s   = rd & (level_q != LVL_ZERO);
    wr_ok_s   = wr & ((level_q != LVL_FULL) | rd_ok_s);
    mem_we_s  = wr_ok_s & ~clr;
    ovf_evt_s = wr & ~wr_ok_s & ~clr;
    udf_evt_s = rd & ~rd_ok_s & ~clr;
  end

  // Next pointers and level; a flush zeroes them and ignores the requests.
  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    level_d = level_q;
    if (clr) begin
      w_ptr_d = PTR_ZERO;
      r_ptr_d = PTR_ZERO;
      level_d = LVL_ZERO;
    end else begin
      if (wr_ok_s) begin
        w_ptr_d = w_ptr_q + PTR_ONE;
      end else begin
        w_ptr_d = w_ptr_q;
      end
      if (rd_ok_s) begin
        r_ptr_d = r_ptr_q + PTR_ONE;
      end else begin
        r_ptr_d = r_ptr_q;
      end
      case ({wr_ok_s, rd_ok_s})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end
  end

  // Sticky error flags: a new error outranks a simultaneous err_clr.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
    end
    if (ovf_evt_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_d;
    end
    if (udf_evt_s) begin
      underflow_d = 1'b1;
    end else begin
      underflow_d = underflow_d;
    end
  end

  // Status decode from the next level so the flags register alongside level.
  always_comb begin
    empty_d        = (level_d == LVL_ZERO);
    full_d         = (level_d == LVL_FULL);
    almost_empty_d = (level_d <= LVL_AE);
    almost_full_d  = (level_d >= LVL_AF);
  end

  // Control and status registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ptr_q        <= PTR_ZERO;
      r_ptr_q        <= PTR_ZERO;
      level_q        <= LVL_ZERO;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
      empty_q        <= 1'b1;
      full_q         <= 1'b0;
      almost_empty_q <= 1'b1;
      almost_full_q  <= 1'b0;
    end else begin
      w_ptr_q        <= w_ptr_d;
      r_ptr_q        <= r_ptr_d;
      level_q        <= level_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
      empty_q        <= empty_d;
      full_q         <= full_d;
      almost_empty_q <= almost_empty_d;
      almost_full_q  <= almost_full_d;
    end
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[w_ptr_q] <= w_data;
    end
  end

  assign r_data       = mem[r_ptr_q];
  assign level        = level_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = almost_empty_q;
  assign almost_full  = almost_full_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_level.sv
// Self-checking bench for fifo_level: queue-based reference model checked
// every cycle, plus directed expectations along the test plan.
module tb_fifo_level;

  localparam int B  = 8;
  localparam int W  = 4;
  localparam int D  = 16;
  localparam int AF = 14;
  localparam int AE = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         clr;
  logic         err_clr;
  logic         wr;
  logic         rd;
  logic [B-1:0] w_data;
  logic [B-1:0] r_data;
  logic         empty, full, almost_empty, almost_full;
  logic [W:0]   level;
  logic         overflow, underflow;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq[$];
  bit         m_ovf = 1'b0;
  bit         m_udf = 1'b0;
  bit         cmp_en = 1'b0;

  fifo_level #(.B(B), .W(W), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .reset(reset), .clr(clr), .err_clr(err_clr),
    .wr(wr), .w_data(w_data), .rd(rd), .r_data(r_data),
    .empty(empty), .full(full), .almost_empty(almost_empty),
    .almost_full(almost_full), .level(level),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour for one clock edge, from the FIFO's rules.
  task automatic model_step(input bit c, input bit ec, input bit w, input bit r, input logic [7:0] d);
    bit rok, wok;
    if (c) begin
      mq.delete();
      if (ec) begin
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end
    end else begin
      rok = r && (mq.size() > 0);
      wok = w && ((mq.size() < D) || rok);
      if (rok) void'(mq.pop_front());
      if (wok) mq.push_back(d);
      if (ec) begin
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end
      if (w && !wok) m_ovf = 1'b1;
      if (r && !rok) m_udf = 1'b1;
    end
  endtask

  task automatic cyc(input bit w, input bit r, input logic [7:0] d,
                     input bit c = 1'b0, input bit ec = 1'b0);
    wr = w; rd = r; w_data = d; clr = c; err_clr = ec;
    @(posedge clk);
    model_step(c, ec, w, r, d);
    #1;
    wr = 1'b0; rd = 1'b0; clr = 1'b0; err_clr = 1'b0;
  endtask

  // Every-cycle comparison against the reference model.
  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      chk("level", level, mq.size());
      chk("empty", empty, mq.size() == 0);
      chk("full", full, mq.size() == D);
      chk("almost_empty", almost_empty, mq.size() <= AE);
      chk("almost_full", almost_full, mq.size() >= AF);
      chk("overflow", overflow, m_ovf);
      chk("underflow", underflow, m_udf);
      if (mq.size() > 0) chk("r_data", r_data, mq[0]);
    end
  end

  initial begin
    reset = 1'b1; clr = 1'b0; err_clr = 1'b0; wr = 1'b0; rd = 1'b0; w_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
    cmp_en = 1'b1;

    // Fill to full, then one rejected write.
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 1'b0, 8'(i));
      if (i == 1) chk("lat_rdata", r_data, 8'h01);
      if (i == 13) chk("af_at13", almost_full, 0);
      if (i == 14) chk("af_at14", almost_full, 1);
    end
    chk("full16", full, 1);
    chk("level16", level, 16);
    cyc(1'b1, 1'b0, 8'h11);
    chk("ovf_17th", overflow, 1);
    chk("level_after_ovf", level, 16);

    // Drain in order, then one rejected read, then clear errors.
    for (int i = 1; i <= 16; i++) begin
      chk("drain_data", r_data, 8'(i));
      cyc(1'b0, 1'b1, 8'h00);
    end
    chk("drained_empty", empty, 1);
    cyc(1'b0, 1'b1, 8'h00);
    chk("udf_set", underflow, 1);
    chk("udf_level0", level, 0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("errclr_ovf", overflow, 0);
    chk("errclr_udf", underflow, 0);

    // Wrap-around.
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 8'(8'h50 + i));
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 8'(8'hA0 + i));
    for (int i = 0; i < 12; i++) begin
      chk("wrap_data", r_data, 8'(8'hA0 + i));
      cyc(1'b0, 1'b1, 8'h00);
    end
    chk("wrap_level", level, 0);
    chk("wrap_wptr", dut.w_ptr_q, 4'd6);
    chk("wrap_rptr", dut.r_ptr_q, 4'd6);

    // Simultaneous read and write while full, then while empty.
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(8'hC0 + i));
    cyc(1'b1, 1'b1, 8'hEE);
    chk("fullrw_level", level, 16);
    chk("fullrw_ovf", overflow, 0);
    chk("fullrw_head", r_data, 8'hC1);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("fullrw_tail", r_data, 8'hEE);
      cyc(1'b0, 1'b1, 8'h00);
    end
    cyc(1'b1, 1'b1, 8'h77);
    chk("emptyrw_level", level, 1);
    chk("emptyrw_udf", underflow, 1);
    chk("emptyrw_data", r_data, 8'h77);
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    chk("errclr_udf2", underflow, 0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    chk("set_beats_clr", underflow, 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Flush with a concurrent write.
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 8'(8'h10 + i));
    chk("pre_clr_level", level, 7);
    cyc(1'b1, 1'b0, 8'h99, 1'b1);
    chk("clr_level", level, 0);
    chk("clr_empty", empty, 1);
    chk("clr_ovf", overflow, 0);
    chk("clr_wptr", dut.w_ptr_q, 4'd0);
    cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("clr_keeps_udf", underflow, 1);

    // Refill, then asynchronous reset between edges.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'h30 + i));
    chk("refill_level", level, 5);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_level", level, 0);
    chk("arst_empty", empty, 1);
    chk("arst_full", full, 0);
    chk("arst_ae", almost_empty, 1);
    chk("arst_af", almost_full, 0);
    chk("arst_ovf", overflow, 0);
    chk("arst_udf", underflow, 0);
    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    #1;
    reset = 1'b0;
    cyc(1'b1, 1'b0, 8'h5A);
    chk("post_rst_addr0", dut.mem[0], 8'h5A);
    chk("post_rst_data", r_data, 8'h5A);
    chk("post_rst_level", level, 1);
    repeat (2) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
